// File: rtl/adc_mon.sv
// ADC window monitor: per-channel debounced window faults, sticky alarm,
// cut permit, snapshot and min/max peak capture behind a 16-bit register map.
module adc_mon #(
  parameter logic [15:0] BAR       = 16'h0000,
  parameter logic [15:0] MASK      = 16'h003F,
  parameter int unsigned ADC_WIDTH = 10,
  parameter int unsigned CHANNELS  = 8,
  parameter int unsigned DB_WIDTH  = 8,
  localparam int unsigned CH_W     = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                 clk,
  input  logic                 aclr,
  input  logic                 sclr,
  input  logic [15:0]          rdaddr,
  input  logic [15:0]          wraddr,
  input  logic [1:0]           be,
  input  logic                 write,
  input  logic [15:0]          wrdata,
  output logic [15:0]          rddata,
  input  logic                 smp_valid,
  input  logic [CH_W-1:0]      smp_ch,
  input  logic [ADC_WIDTH-1:0] smp_data,
  input  logic                 smp_err,
  output logic                 cut_permit,
  output logic                 alarm,
  output logic                 irq
);

  localparam int unsigned CW = DB_WIDTH + 1;

  logic [ADC_WIDTH-1:0] r_low, r_high;
  logic [DB_WIDTH-1:0]  r_debounce;
  logic [CHANNELS-1:0]  r_ch_ena, r_fault;
  logic                 r_fb_ena, r_soft_permit, r_irq_ena, r_alarm;
  logic [DB_WIDTH-1:0]  r_cnt       [CHANNELS];
  logic [ADC_WIDTH-1:0] r_last_data [CHANNELS];
  logic [ADC_WIDTH-1:0] r_snap_data [CHANNELS];
  logic [ADC_WIDTH-1:0] r_min       [CHANNELS];
  logic [ADC_WIDTH-1:0] r_max       [CHANNELS];
  logic [CHANNELS-1:0]  r_last_err, r_snap_err;

  logic [15:0]          w_rd_loc, w_wr_loc, w_rd_val;
  logic                 w_rd_hit, w_wr_hit, w_acc, w_oow, w_fault_en;
  logic                 w_wr_ctrl, w_wr_stat, w_snap, w_pclr, w_alarm_set, w_alarm_clr;
  logic [CHANNELS-1:0]  w_take;

  function automatic logic [15:0] f_merge(input logic [15:0] old_v, input logic [15:0] new_v,
                                          input logic [1:0] lanes);
    f_merge = {lanes[1] ? new_v[15:8] : old_v[15:8], lanes[0] ? new_v[7:0] : old_v[7:0]};
  endfunction

  assign w_rd_hit    = (rdaddr & ~MASK) == BAR;
  assign w_wr_hit    = write && ((wraddr & ~MASK) == BAR);
  assign w_rd_loc    = rdaddr & MASK;
  assign w_wr_loc    = wraddr & MASK;
  assign w_wr_ctrl   = w_wr_hit && (w_wr_loc == 16'h0010);
  assign w_wr_stat   = w_wr_hit && (w_wr_loc == 16'h0012);
  assign w_snap      = w_wr_ctrl && be[0] && wrdata[0];
  assign w_pclr      = w_wr_ctrl && be[0] && wrdata[3];
  assign w_acc       = smp_valid && (32'(smp_ch) < CHANNELS);
  assign w_oow       = smp_err || (smp_data < r_low) || (smp_data > r_high);
  assign w_fault_en  = |(r_fault & r_ch_ena);
  assign w_alarm_set = r_fb_ena && w_fault_en;
  assign w_alarm_clr = w_wr_stat && be[0] && wrdata[1];

  assign cut_permit = r_soft_permit && (!r_fb_ena || !w_fault_en);
  assign alarm      = r_alarm;
  assign irq        = r_alarm && r_irq_ena;

  // one-hot channel select for the accepted sample
  always_comb begin
    w_take = '0;
    for (int n = 0; n < CHANNELS; n++) w_take[n] = w_acc && (smp_ch == CH_W'(n));
  end

  // read decode
  always_comb begin
    w_rd_val = '0;
    if (w_rd_hit) begin
      case (w_rd_loc)
        16'h0010: w_rd_val = {11'd0, r_irq_ena, 1'b0, r_soft_permit, r_fb_ena, 1'b0};
        16'h0012: begin
          w_rd_val[0]             = !cut_permit;
          w_rd_val[1]             = r_alarm;
          w_rd_val[8 +: CHANNELS] = r_fault;
        end
        16'h0014: w_rd_val = 16'(r_low);
        16'h0016: w_rd_val = 16'(r_high);
        16'h0018: w_rd_val = 16'(r_debounce);
        16'h001A: w_rd_val = 16'(r_ch_ena);
        default:  w_rd_val = '0;
      endcase
      for (int n = 0; n < CHANNELS; n++) begin
        if (w_rd_loc == 16'(2 * n)) begin
          w_rd_val     = 16'(r_snap_data[n]);
          w_rd_val[15] = r_snap_err[n];
        end
        if (w_rd_loc == 16'(32 + 2 * n)) w_rd_val = 16'(r_min[n]);
        if (w_rd_loc == 16'(48 + 2 * n)) w_rd_val = 16'(r_max[n]);
      end
    end
  end

  always_ff @(posedge clk or posedge aclr) begin
    if (aclr) begin
      r_low <= '0; r_high <= '1; r_debounce <= '0; r_ch_ena <= '1;
      r_fb_ena <= 1'b0; r_soft_permit <= 1'b1; r_irq_ena <= 1'b0; r_alarm <= 1'b0;
      r_fault <= '0; r_last_err <= '0; r_snap_err <= '0; rddata <= '0;
      for (int n = 0; n < CHANNELS; n++) begin
        r_cnt[n] <= '0; r_last_data[n] <= '0; r_snap_data[n] <= '0;
        r_min[n] <= '1; r_max[n] <= '0;
      end
    end else if (sclr) begin
      r_low <= '0; r_high <= '1; r_debounce <= '0; r_ch_ena <= '1;
      r_fb_ena <= 1'b0; r_soft_permit <= 1'b1; r_irq_ena <= 1'b0; r_alarm <= 1'b0;
      r_fault <= '0; r_last_err <= '0; r_snap_err <= '0; rddata <= '0;
      for (int n = 0; n < CHANNELS; n++) begin
        r_cnt[n] <= '0; r_last_data[n] <= '0; r_snap_data[n] <= '0;
        r_min[n] <= '1; r_max[n] <= '0;
      end
    end else begin
      rddata <= w_rd_val;
      if (w_wr_hit && (w_wr_loc == 16'h0014)) r_low      <= ADC_WIDTH'(f_merge(16'(r_low), wrdata, be));
      if (w_wr_hit && (w_wr_loc == 16'h0016)) r_high     <= ADC_WIDTH'(f_merge(16'(r_high), wrdata, be));
      if (w_wr_hit && (w_wr_loc == 16'h0018)) r_debounce <= DB_WIDTH'(f_merge(16'(r_debounce), wrdata, be));
      if (w_wr_hit && (w_wr_loc == 16'h001A)) r_ch_ena   <= CHANNELS'(f_merge(16'(r_ch_ena), wrdata, be));
      if (w_wr_ctrl && be[0]) begin
        r_fb_ena      <= wrdata[1];
        r_soft_permit <= wrdata[2];
        r_irq_ena     <= wrdata[4];
      end
      // set has priority over the W1C clear
      if (w_alarm_set)      r_alarm <= 1'b1;
      else if (w_alarm_clr) r_alarm <= 1'b0;
      // snapshot takes LAST as it stood before any same-cycle sample
      if (w_snap) begin
        r_snap_err <= r_last_err;
        for (int n = 0; n < CHANNELS; n++) r_snap_data[n] <= r_last_data[n];
      end
      for (int n = 0; n < CHANNELS; n++) begin
        if (w_take[n]) begin
          r_last_data[n] <= smp_data;
          r_last_err[n]  <= smp_err;
          if (w_oow) begin
            r_cnt[n] <= (&r_cnt[n]) ? r_cnt[n] : r_cnt[n] + DB_WIDTH'(1);
            if ((CW'(r_cnt[n]) + CW'(1)) >= CW'(r_debounce)) r_fault[n] <= 1'b1;
          end else begin
            r_cnt[n]   <= '0;
            r_fault[n] <= 1'b0;
          end
        end
        if (w_take[n] && !smp_err) begin
          r_min[n] <= (w_pclr || (smp_data < r_min[n])) ? smp_data : r_min[n];
          r_max[n] <= (w_pclr || (smp_data > r_max[n])) ? smp_data : r_max[n];
        end else if (w_pclr) begin
          r_min[n] <= '1;
          r_max[n] <= '0;
        end
      end
    end
  end

endmodule

// File: tb/tb_adc_mon.sv
// Self-checking bench for adc_mon (6 channels so an out-of-range index exists).
module tb_adc_mon;

  logic        clk = 1'b0;
  logic        aclr, sclr;
  logic [15:0] rdaddr, wraddr, wrdata, rddata;
  logic [1:0]  be;
  logic        write;
  logic        smp_valid, smp_err;
  logic [2:0]  smp_ch;
  logic [9:0]  smp_data;
  logic        cut_permit, alarm, irq;

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;
  logic [15:0] q_exp[$];
  string       q_tag[$];

  adc_mon #(.CHANNELS(6)) dut (
    .clk(clk), .aclr(aclr), .sclr(sclr),
    .rdaddr(rdaddr), .wraddr(wraddr), .be(be), .write(write), .wrdata(wrdata), .rddata(rddata),
    .smp_valid(smp_valid), .smp_ch(smp_ch), .smp_data(smp_data), .smp_err(smp_err),
    .cut_permit(cut_permit), .alarm(alarm), .irq(irq)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cyc(input logic we, input logic [15:0] wa, input logic [15:0] wd, input logic [1:0] b,
                     input logic sv, input logic [2:0] ch, input logic [9:0] d, input logic e);
    write = we; wraddr = wa; wrdata = wd; be = b;
    smp_valid = sv; smp_ch = ch; smp_data = d; smp_err = e;
    tick();
    write = 1'b0; smp_valid = 1'b0;
  endtask

  task automatic wr(input logic [15:0] a, input logic [15:0] d);
    cyc(1'b1, a, d, 2'b11, 1'b0, 3'd0, 10'd0, 1'b0);
  endtask

  task automatic smp(input logic [2:0] ch, input logic [9:0] d, input logic e);
    cyc(1'b0, 16'h0, 16'h0, 2'b00, 1'b1, ch, d, e);
  endtask

  // expected read value queued when the address is driven, checked when rddata lands
  task automatic rd(input logic [15:0] a, input logic [15:0] exp, input string tag);
    rdaddr = a;
    q_exp.push_back(exp);
    q_tag.push_back(tag);
    tick();
    chk(q_tag.pop_front(), rddata, q_exp.pop_front());
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    aclr = 1'b1; sclr = 1'b0; rdaddr = '0; wraddr = '0; wrdata = '0; be = '0; write = 1'b0;
    smp_valid = 1'b0; smp_ch = '0; smp_data = '0; smp_err = 1'b0;
    repeat (3) @(posedge clk);
    #1 aclr = 1'b0;
    tick();

    chk("rst_cut", 16'(cut_permit), 16'd1);
    chk("rst_alarm", 16'(alarm), 16'd0);
    chk("rst_irq", 16'(irq), 16'd0);
    rd(16'h10, 16'h0004, "rst_ctrl");
    rd(16'h14, 16'h0000, "rst_low");
    rd(16'h16, 16'h03FF, "rst_high");
    rd(16'h1A, 16'h003F, "rst_chena");
    rd(16'h0056, 16'h0000, "nonhit");
    rd(16'h20, 16'h03FF, "rst_min0");

    // debounced fault on ch2
    wr(16'h14, 16'h0100); wr(16'h16, 16'h0300); wr(16'h18, 16'h0003); wr(16'h10, 16'h0006);
    smp(3'd2, 10'h050, 1'b0); chk("db1_cut", 16'(cut_permit), 16'd1);
    smp(3'd2, 10'h050, 1'b0); chk("db2_cut", 16'(cut_permit), 16'd1);
    smp(3'd2, 10'h050, 1'b0); chk("db3_cut", 16'(cut_permit), 16'd0);
    tick();
    chk("db3_alarm", 16'(alarm), 16'd1);
    rd(16'h12, 16'h0403, "db3_status");
    smp(3'd2, 10'h200, 1'b0);
    chk("good_cut", 16'(cut_permit), 16'd1);
    chk("good_alarm", 16'(alarm), 16'd1);
    smp(3'd3, 10'h100, 1'b0); smp(3'd3, 10'h300, 1'b0);
    rd(16'h12, 16'h0002, "bound_status");
    wr(16'h12, 16'h0002);
    chk("w1c_alarm", 16'(alarm), 16'd0);

    // channel enable masking and soft permit
    wr(16'h1A, 16'h00FB);
    smp(3'd2, 10'h050, 1'b0); smp(3'd2, 10'h050, 1'b0); smp(3'd2, 10'h050, 1'b0);
    tick();
    chk("mask_cut", 16'(cut_permit), 16'd1);
    chk("mask_alarm", 16'(alarm), 16'd0);
    rd(16'h12, 16'h0400, "mask_status");
    rd(16'h1A, 16'h003B, "chena_rd");
    wr(16'h10, 16'h0002);
    chk("soft_cut", 16'(cut_permit), 16'd0);
    wr(16'h10, 16'h0006); wr(16'h1A, 16'h00FF);
    chk("unmask_cut", 16'(cut_permit), 16'd0);
    tick();
    chk("unmask_alarm", 16'(alarm), 16'd1);

    // irq and W1C versus persisting fault
    wr(16'h10, 16'h0016);
    chk("irq_on", 16'(irq), 16'd1);
    wr(16'h12, 16'h0002);
    chk("w1c_persist", 16'(alarm), 16'd1);
    smp(3'd2, 10'h200, 1'b0);
    wr(16'h12, 16'h0002);
    chk("w1c_alarm2", 16'(alarm), 16'd0);
    chk("irq_off", 16'(irq), 16'd0);

    // snapshot and peaks
    smp(3'd0, 10'h123, 1'b0); smp(3'd0, 10'h045, 1'b0); smp(3'd0, 10'h3F0, 1'b0);
    chk("peak_cut", 16'(cut_permit), 16'd1);
    wr(16'h10, 16'h0017);
    rd(16'h00, 16'h03F0, "snap0");
    rd(16'h20, 16'h0045, "min0");
    rd(16'h30, 16'h03F0, "max0");
    rd(16'h10, 16'h0016, "ctrl_pulse");
    smp(3'd1, 10'h222, 1'b0);
    cyc(1'b1, 16'h10, 16'h0017, 2'b11, 1'b1, 3'd0, 10'h111, 1'b0);
    rd(16'h00, 16'h03F0, "snap_excl");
    cyc(1'b1, 16'h10, 16'h001E, 2'b11, 1'b1, 3'd0, 10'h111, 1'b0);
    rd(16'h20, 16'h0111, "pclr_min0");
    rd(16'h30, 16'h0111, "pclr_max0");
    rd(16'h22, 16'h03FF, "pclr_min1");
    rd(16'h32, 16'h0000, "pclr_max1");

    // error sample, zero debounce, out-of-range channel
    wr(16'h18, 16'h0000);
    smp(3'd1, 10'h200, 1'b1);
    rd(16'h12, 16'h0201, "err_status");
    chk("err_alarm", 16'(alarm), 16'd1);
    chk("err_irq", 16'(irq), 16'd1);
    rd(16'h22, 16'h03FF, "err_min1");
    rd(16'h32, 16'h0000, "err_max1");
    wr(16'h10, 16'h0017);
    rd(16'h02, 16'h8200, "snap1_err");
    smp(3'd1, 10'h200, 1'b0);
    wr(16'h12, 16'h0002);
    smp(3'd6, 10'h050, 1'b1);
    smp(3'd7, 10'h050, 1'b0);
    tick();
    chk("oor_alarm", 16'(alarm), 16'd0);
    chk("oor_cut", 16'(cut_permit), 16'd1);
    rd(16'h12, 16'h0000, "oor_status");
    rd(16'h20, 16'h0111, "oor_min0");

    // synchronous clear mid-debounce
    wr(16'h18, 16'h0003);
    smp(3'd4, 10'h050, 1'b0); smp(3'd4, 10'h050, 1'b0);
    sclr = 1'b1; tick(); sclr = 1'b0;
    rd(16'h10, 16'h0004, "sclr_ctrl");
    rd(16'h16, 16'h03FF, "sclr_high");
    rd(16'h02, 16'h0000, "sclr_snap1");
    rd(16'h22, 16'h03FF, "sclr_min1");
    wr(16'h14, 16'h0100); wr(16'h18, 16'h0003); wr(16'h10, 16'h0006);
    smp(3'd4, 10'h050, 1'b0);
    chk("sclr_db1_cut", 16'(cut_permit), 16'd1);
    smp(3'd4, 10'h050, 1'b0); smp(3'd4, 10'h050, 1'b0);
    chk("sclr_db3_cut", 16'(cut_permit), 16'd0);

    // byte lanes
    cyc(1'b1, 16'h16, 16'hAB55, 2'b01, 1'b0, 3'd0, 10'd0, 1'b0);
    rd(16'h16, 16'h0355, "be_lo");
    cyc(1'b1, 16'h16, 16'h0100, 2'b10, 1'b0, 3'd0, 10'd0, 1'b0);
    rd(16'h16, 16'h0155, "be_hi");
    rd(16'h1C, 16'h0000, "unmapped");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
